// File: rtl/niosduino_pll_reset_sequencer.sv
// rtl/niosduino_pll_reset_sequencer.sv - PLL reset and ordered system/peripheral reset release sequencer
//
// Purpose:
//   Runs on the free-running reference clock. Holds the PLL in reset, waits for a
//   qualified lock, then releases the system reset and later the peripheral reset.
//   Lock loss re-runs the whole sequence. A software request re-holds system and
//   peripheral resets without touching the PLL.
//
// Ports:
//   i_clk             free-running reference clock
//   i_reset_n         asynchronous active-low reset
//   i_pll_locked      PLL locked flag (asynchronous to i_clk)
//   i_sw_reset_req    single-cycle software reset request (synchronous)
//   o_pll_rst         active-high PLL reset
//   o_sys_reset_n     active-low system reset
//   o_periph_reset_n  active-low peripheral reset
//   o_seq_state       current state (0 PLL_RST, 1 WAIT_LOCK, 2 SYS_UP, 3 RUN, 4 SW_HOLD)
//   o_relock_count    lock-loss events since reset, saturating at 255
//   o_timeout_err     sticky lock-timeout flag
module niosduino_pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int LOSS_FILTER_CYCLES  = 4,
  parameter int PERIPH_DELAY_CYCLES = 64,
  parameter int SW_RESET_CYCLES     = 32,
  parameter int CNT_W               = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_pll_locked,
  input  logic       i_sw_reset_req,
  output logic       o_pll_rst,
  output logic       o_sys_reset_n,
  output logic       o_periph_reset_n,
  output logic [2:0] o_seq_state,
  output logic [7:0] o_relock_count,
  output logic       o_timeout_err
);

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_SYS_UP    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_SW_HOLD   = 3'd4;

  // Terminal counts: a counter equal to N-1 on a clock edge means N cycles elapsed.
  localparam logic [CNT_W-1:0] L_PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_LOSS_LAST    = CNT_W'(LOSS_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_PERIPH_LAST  = CNT_W'(PERIPH_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_SW_LAST      = CNT_W'(SW_RESET_CYCLES - 1);

  logic [1:0]       r_sync;
  logic             w_lk_s;
  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_stable_cnt;
  logic [CNT_W-1:0] r_loss_cnt;
  logic             w_loss_window;
  logic             w_lock_loss;
  logic             w_stable_done;
  logic             w_pll_rst_next;
  logic             w_sys_reset_n_next;
  logic             w_periph_reset_n_next;

  assign w_lk_s = r_sync[1];

  // Lock loss is only watched once the system is (or has been) released.
  assign w_loss_window = (r_state == ST_SYS_UP) || (r_state == ST_RUN) || (r_state == ST_SW_HOLD);
  assign w_lock_loss   = w_loss_window && !w_lk_s && (r_loss_cnt == L_LOSS_LAST);
  assign w_stable_done = (r_state == ST_WAIT_LOCK) && w_lk_s && (r_stable_cnt == L_STABLE_LAST);

  // State register plus counters and status.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync           <= 2'b00;
      r_state          <= ST_PLL_RST;
      r_phase_cnt      <= '0;
      r_stable_cnt     <= '0;
      r_loss_cnt       <= '0;
      o_pll_rst        <= 1'b1;
      o_sys_reset_n    <= 1'b0;
      o_periph_reset_n <= 1'b0;
      o_relock_count   <= 8'd0;
      o_timeout_err    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_pll_locked};
      r_state <= w_state_next;

      if ((w_state_next != r_state) || (r_state == ST_RUN))
        r_phase_cnt <= '0;
      else
        r_phase_cnt <= r_phase_cnt + 1'b1;

      if ((r_state == ST_WAIT_LOCK) && (w_state_next == ST_WAIT_LOCK) && w_lk_s)
        r_stable_cnt <= r_stable_cnt + 1'b1;
      else
        r_stable_cnt <= '0;

      // Consecutive-low count survives SYS_UP/RUN/SW_HOLD moves; any high clears it.
      if (w_loss_window && !w_lk_s && !w_lock_loss)
        r_loss_cnt <= r_loss_cnt + 1'b1;
      else
        r_loss_cnt <= '0;

      if (w_lock_loss && (o_relock_count != 8'hFF))
        o_relock_count <= o_relock_count + 8'd1;

      if ((r_state == ST_WAIT_LOCK) && (w_state_next == ST_PLL_RST))
        o_timeout_err <= 1'b1;

      o_pll_rst        <= w_pll_rst_next;
      o_sys_reset_n    <= w_sys_reset_n_next;
      o_periph_reset_n <= w_periph_reset_n_next;
    end
  end

  // Next-state logic. Lock loss beats a software request; a stable lock beats a timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_PLL_RST: begin
        if (r_phase_cnt == L_PLL_RST_LAST) w_state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_stable_done)                      w_state_next = ST_SYS_UP;
        else if (r_phase_cnt == L_TIMEOUT_LAST) w_state_next = ST_PLL_RST;
      end
      ST_SYS_UP: begin
        if (w_lock_loss)                       w_state_next = ST_PLL_RST;
        else if (i_sw_reset_req)               w_state_next = ST_SW_HOLD;
        else if (r_phase_cnt == L_PERIPH_LAST) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_lock_loss)         w_state_next = ST_PLL_RST;
        else if (i_sw_reset_req) w_state_next = ST_SW_HOLD;
      end
      ST_SW_HOLD: begin
        if (w_lock_loss)                   w_state_next = ST_PLL_RST;
        else if (r_phase_cnt == L_SW_LAST) w_state_next = ST_SYS_UP;
      end
      default: w_state_next = ST_PLL_RST;
    endcase
  end

  // Output decode from the next state so the registered outputs change on the transition edge.
  always_comb begin
    w_pll_rst_next        = (w_state_next == ST_PLL_RST);
    w_sys_reset_n_next    = (w_state_next == ST_SYS_UP) || (w_state_next == ST_RUN);
    w_periph_reset_n_next = (w_state_next == ST_RUN);
  end

  assign o_seq_state = r_state;

endmodule
